// File: rtl/mc_pkg.sv
// ============================================================================
// mc_pkg : shared constants and types for the multi-cycle MIPS control unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef enum logic [3:0] {
    S_IF        = 4'd0,
    S_ID        = 4'd1,
    S_EX_R      = 4'd2,
    S_EX_I      = 4'd3,
    S_EX_MEMADR = 4'd4,
    S_EX_BR     = 4'd5,
    S_EX_J      = 4'd6,
    S_EX_JAL    = 4'd7,
    S_EX_JR     = 4'd8,
    S_MEM_RD    = 4'd9,
    S_MEM_WR    = 4'd10,
    S_WB_R      = 4'd11,
    S_WB_I      = 4'd12,
    S_WB_MEM    = 4'd13,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_LUI = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;

  localparam logic [1:0] NPC_ALU = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JMP = 2'b10;
  localparam logic [1:0] NPC_RS  = 2'b11;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // States that hold for the memory ready handshake.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
// ============================================================================
// multicycle_control_if : IR fields in, datapath enables and status out
// Revision: 1.0
// ============================================================================
`default_nettype none

interface multicycle_control_if #(
  parameter int ALUCTR_W = 3
);
  logic [5:0]          op;
  logic [5:0]          func;
  logic                zero;
  logic                mem_ready;
  logic                pc_wr;
  logic                pc_wr_cond;
  logic [1:0]          npc_sel;
  logic                ir_wr;
  logic                i_or_d;
  logic                mem_req;
  logic                mem_wr;
  logic [1:0]          reg_dst;
  logic [1:0]          mem_to_reg;
  logic                reg_wr;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic                ext_op;
  logic [ALUCTR_W-1:0] alu_ctr;
  logic                instr_done;
  logic                illegal_op;
  logic                mem_timeout;
  logic [3:0]          state_dbg;

  modport master (
    input  op, func, zero, mem_ready,
    output pc_wr, pc_wr_cond, npc_sel, ir_wr, i_or_d, mem_req, mem_wr,
           reg_dst, mem_to_reg, reg_wr, alu_src_a, alu_src_b, ext_op,
           alu_ctr, instr_done, illegal_op, mem_timeout, state_dbg
  );

  modport slave (
    output op, func, zero, mem_ready,
    input  pc_wr, pc_wr_cond, npc_sel, ir_wr, i_or_d, mem_req, mem_wr,
           reg_dst, mem_to_reg, reg_wr, alu_src_a, alu_src_b, ext_op,
           alu_ctr, instr_done, illegal_op, mem_timeout, state_dbg
  );
endinterface

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// ============================================================================
// mc_wait_timer : counts consecutive un-ready wait cycles, flags the limit
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_wait_timer #(
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_waiting,
  input  logic i_ready,
  output logic o_expire
);
  localparam int CW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  logic [CW-1:0] r_count;

  // No wait state is ever left without ready or expiry, so clearing on
  // "not waiting or ready" also covers every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_waiting && !i_ready) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= '0;
    end
  end

  generate
    if (WAIT_TIMEOUT > 0) begin : g_limit
      assign o_expire = i_waiting && !i_ready && (r_count == CW'(WAIT_TIMEOUT - 1));
    end else begin : g_no_limit
      assign o_expire = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB)
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control
  import mc_pkg::*;
#(
  parameter int ALUCTR_W     = 3,
  parameter int HAS_JR       = 1,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);
  state_t     r_state;
  state_t     w_next;
  state_t     w_dispatch;
  logic       r_illegal_op;
  logic       r_mem_timeout;
  logic       w_expire;
  logic [2:0] w_alu;

  mc_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_waiting(is_wait_state(r_state)),
    .i_ready  (bus.mem_ready),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IF;
      r_illegal_op  <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ID && w_next == S_TRAP) r_illegal_op <= 1'b1;
      if (w_expire) r_mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_dispatch = S_TRAP;
    case (bus.op)
      OP_RTYPE: begin
        if (bus.func == FN_ADDU || bus.func == FN_SUBU) w_dispatch = S_EX_R;
        else if (HAS_JR != 0 && bus.func == FN_JR)      w_dispatch = S_EX_JR;
      end
      OP_ORI, OP_LUI: w_dispatch = S_EX_I;
      OP_LW, OP_SW:   w_dispatch = S_EX_MEMADR;
      OP_BEQ:         w_dispatch = S_EX_BR;
      OP_J:           w_dispatch = S_EX_J;
      OP_JAL:         w_dispatch = S_EX_JAL;
      default:        w_dispatch = S_TRAP;
    endcase
  end

  always_comb begin
    w_next         = r_state;
    w_alu          = ALU_ADD;
    bus.pc_wr      = 1'b0;
    bus.pc_wr_cond = 1'b0;
    bus.npc_sel    = NPC_ALU;
    bus.ir_wr      = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.reg_dst    = RDST_RT;
    bus.mem_to_reg = M2R_ALU;
    bus.reg_wr     = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_RT;
    bus.ext_op     = 1'b0;
    bus.instr_done = 1'b0;
    case (r_state)
      S_IF: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        if (w_expire) begin
          w_next = S_TRAP;
        end else if (bus.mem_ready) begin
          bus.ir_wr = 1'b1;
          bus.pc_wr = 1'b1;
          w_next    = S_ID;
        end
      end
      S_ID: begin
        bus.alu_src_b = SRCB_IMM_SH;
        bus.ext_op    = 1'b1;
        w_next        = w_dispatch;
      end
      S_EX_R: begin
        bus.alu_src_a = 1'b1;
        w_alu         = (bus.func == FN_SUBU) ? ALU_SUB : ALU_ADD;
        w_next        = S_WB_R;
      end
      S_EX_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        w_alu         = (bus.op == OP_ORI) ? ALU_OR : ALU_LUI;
        w_next        = S_WB_I;
      end
      S_EX_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.ext_op    = 1'b1;
        w_next        = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_EX_BR: begin
        bus.alu_src_a  = 1'b1;
        w_alu          = ALU_SUB;
        bus.pc_wr_cond = 1'b1;
        bus.npc_sel    = NPC_BR;
        bus.instr_done = 1'b1;
        w_next         = S_IF;
      end
      S_EX_J, S_EX_JR: begin
        bus.pc_wr      = 1'b1;
        bus.npc_sel    = (r_state == S_EX_JR) ? NPC_RS : NPC_JMP;
        bus.instr_done = 1'b1;
        w_next         = S_IF;
      end
      S_EX_JAL: begin
        // PC already holds the return address after the fetch increment.
        bus.pc_wr      = 1'b1;
        bus.npc_sel    = NPC_JMP;
        bus.reg_wr     = 1'b1;
        bus.reg_dst    = RDST_RA;
        bus.mem_to_reg = M2R_PC;
        bus.instr_done = 1'b1;
        w_next         = S_IF;
      end
      S_MEM_RD, S_MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.i_or_d  = 1'b1;
        bus.mem_wr  = (r_state == S_MEM_WR);
        if (w_expire) begin
          w_next = S_TRAP;
        end else if (bus.mem_ready) begin
          bus.instr_done = (r_state == S_MEM_WR);
          w_next         = (r_state == S_MEM_WR) ? S_IF : S_WB_MEM;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM: begin
        bus.reg_wr     = 1'b1;
        bus.reg_dst    = (r_state == S_WB_R) ? RDST_RD : RDST_RT;
        bus.mem_to_reg = (r_state == S_WB_MEM) ? M2R_MDR : M2R_ALU;
        bus.instr_done = 1'b1;
        w_next         = S_IF;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
    bus.alu_ctr = ALUCTR_W'(w_alu);
  end

  assign bus.illegal_op  = r_illegal_op;
  assign bus.mem_timeout = r_mem_timeout;
  assign bus.state_dbg   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control : scoreboard bench, dut0 (no jr, timeout 4) and
// dut1 (jr, no timeout) run the same instruction stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  localparam logic [3:0] T_IF = 4'd0,  T_ID = 4'd1,  T_EXR = 4'd2,  T_EXI = 4'd3;
  localparam logic [3:0] T_EXM = 4'd4, T_EXB = 4'd5, T_EXJ = 4'd6,  T_JAL = 4'd7;
  localparam logic [3:0] T_JR = 4'd8,  T_MRD = 4'd9, T_MWR = 4'd10, T_WBR = 4'd11;
  localparam logic [3:0] T_WBI = 4'd12, T_WBM = 4'd13, T_TRAP = 4'd15;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [20:0] ctrl;
    logic [1:0]  flg;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic [5:0] cur_op;
  logic [5:0] cur_fn;
  exp_t q0[$];
  exp_t q1[$];

  multicycle_control_if #(.ALUCTR_W(3)) bus0 ();
  multicycle_control_if #(.ALUCTR_W(3)) bus1 ();

  assign bus1.op        = bus0.op;
  assign bus1.func      = bus0.func;
  assign bus1.zero      = bus0.zero;
  assign bus1.mem_ready = bus0.mem_ready;

  multicycle_control #(.ALUCTR_W(3), .HAS_JR(0), .WAIT_TIMEOUT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  multicycle_control #(.ALUCTR_W(3), .HAS_JR(1), .WAIT_TIMEOUT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  logic [20:0] ctrl0, ctrl1;
  assign ctrl0 = {bus0.pc_wr, bus0.pc_wr_cond, bus0.npc_sel, bus0.ir_wr, bus0.i_or_d,
                  bus0.mem_req, bus0.mem_wr, bus0.reg_dst, bus0.mem_to_reg, bus0.reg_wr,
                  bus0.alu_src_a, bus0.alu_src_b, bus0.ext_op, bus0.alu_ctr, bus0.instr_done};
  assign ctrl1 = {bus1.pc_wr, bus1.pc_wr_cond, bus1.npc_sel, bus1.ir_wr, bus1.i_or_d,
                  bus1.mem_req, bus1.mem_wr, bus1.reg_dst, bus1.mem_to_reg, bus1.reg_wr,
                  bus1.alu_src_a, bus1.alu_src_b, bus1.ext_op, bus1.alu_ctr, bus1.instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected control bundle for a state, written from the state table.
  function automatic logic [20:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                           input logic [5:0] fn, input logic rdy);
    logic pcw, pcc, irw, iod, mreq, mwr, rw, srca, ext, done;
    logic [1:0] npc, rdst, m2r, srcb;
    logic [2:0] alu;
    {pcw, pcc, irw, iod, mreq, mwr, rw, srca, ext, done} = '0;
    {npc, rdst, m2r, srcb} = '0;
    alu = 3'd0;
    case (st)
      T_IF:  begin mreq = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      T_ID:  begin srcb = 2'b11; ext = 1; end
      T_EXR: begin srca = 1; alu = (fn == 6'b100011) ? 3'd1 : 3'd0; end
      T_EXI: begin srca = 1; srcb = 2'b10; alu = (op == 6'b001101) ? 3'd4 : 3'd3; end
      T_EXM: begin srca = 1; srcb = 2'b10; ext = 1; end
      T_EXB: begin srca = 1; alu = 3'd1; pcc = 1; npc = 2'b01; done = 1; end
      T_EXJ: begin pcw = 1; npc = 2'b10; done = 1; end
      T_JAL: begin pcw = 1; npc = 2'b10; rw = 1; rdst = 2'b10; m2r = 2'b10; done = 1; end
      T_JR:  begin pcw = 1; npc = 2'b11; done = 1; end
      T_MRD: begin mreq = 1; iod = 1; end
      T_MWR: begin mreq = 1; mwr = 1; iod = 1; done = rdy; end
      T_WBR: begin rw = 1; rdst = 2'b01; done = 1; end
      T_WBI: begin rw = 1; done = 1; end
      T_WBM: begin rw = 1; m2r = 2'b01; done = 1; end
      default: ;
    endcase
    return {pcw, pcc, npc, irw, iod, mreq, mwr, rdst, m2r, rw, srca, srcb, ext, alu, done};
  endfunction

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn, input logic z);
    cur_op = op;  cur_fn = fn;
    bus0.op = op; bus0.func = fn; bus0.zero = z;
  endtask

  // One clock: drive mem_ready, push expectations, compare at the falling edge.
  task automatic cyc(input string tag, input logic [3:0] s0, input logic [3:0] s1,
                     input logic rdy, input logic [1:0] f0, input logic [1:0] f1);
    exp_t e;
    bus0.mem_ready = rdy;
    q0.push_back('{tag, s0, exp_ctrl(s0, cur_op, cur_fn, rdy), f0});
    q1.push_back('{tag, s1, exp_ctrl(s1, cur_op, cur_fn, rdy), f1});
    @(negedge clk);
    while (q0.size() > 0) begin
      e = q0.pop_front();
      check({e.tag, "/st0"}, 32'(bus0.state_dbg), 32'(e.st));
      check({e.tag, "/ctrl0"}, 32'(ctrl0), 32'(e.ctrl));
      check({e.tag, "/flg0"}, 32'({bus0.illegal_op, bus0.mem_timeout}), 32'(e.flg));
    end
    while (q1.size() > 0) begin
      e = q1.pop_front();
      check({e.tag, "/st1"}, 32'(bus1.state_dbg), 32'(e.st));
      check({e.tag, "/ctrl1"}, 32'(ctrl1), 32'(e.ctrl));
      check({e.tag, "/flg1"}, 32'({bus1.illegal_op, bus1.mem_timeout}), 32'(e.flg));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_s(input string tag, input logic [3:0] s, input logic rdy);
    cyc(tag, s, s, rdy, 2'b00, 2'b00);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "/st"}, 32'(bus0.state_dbg), 32'(T_IF));
    check({tag, "/mem_wr"}, 32'(bus0.mem_wr), 32'd0);
    check({tag, "/flags"}, 32'({bus0.illegal_op, bus0.mem_timeout, bus1.illegal_op}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus0.mem_ready = 1'b0;
    set_ir(6'h00, 6'h21, 1'b0);
    @(posedge clk);
    #1;
    check("reset/st", 32'(bus0.state_dbg), 32'(T_IF));
    check("reset/ctrl", 32'(ctrl0), 32'(exp_ctrl(T_IF, cur_op, cur_fn, 1'b0)));
    check("reset/flags", 32'({bus0.illegal_op, bus0.mem_timeout}), 32'd0);
    rst_n = 1'b1;

    set_ir(6'h00, 6'h21, 1'b0);
    cyc_s("addu", T_IF, 1); cyc_s("addu", T_ID, 1); cyc_s("addu", T_EXR, 1); cyc_s("addu", T_WBR, 1);
    set_ir(6'h00, 6'h23, 1'b0);
    cyc_s("subu", T_IF, 1); cyc_s("subu", T_ID, 1); cyc_s("subu", T_EXR, 1); cyc_s("subu", T_WBR, 1);
    set_ir(6'h0D, 6'h00, 1'b0);
    cyc_s("ori", T_IF, 1); cyc_s("ori", T_ID, 1); cyc_s("ori", T_EXI, 1); cyc_s("ori", T_WBI, 1);
    set_ir(6'h0F, 6'h00, 1'b0);
    cyc_s("lui", T_IF, 1); cyc_s("lui", T_ID, 1); cyc_s("lui", T_EXI, 1); cyc_s("lui", T_WBI, 1);

    set_ir(6'h23, 6'h00, 1'b0);
    cyc_s("lw", T_IF, 1); cyc_s("lw", T_ID, 1); cyc_s("lw", T_EXM, 1);
    cyc_s("lw", T_MRD, 0); cyc_s("lw", T_MRD, 0); cyc_s("lw", T_MRD, 1); cyc_s("lw", T_WBM, 1);

    set_ir(6'h2B, 6'h00, 1'b0);
    cyc_s("sw", T_IF, 0); cyc_s("sw", T_IF, 1); cyc_s("sw", T_ID, 1);
    cyc_s("sw", T_EXM, 1); cyc_s("sw", T_MWR, 1);

    set_ir(6'h04, 6'h00, 1'b1);
    cyc_s("beq_z1", T_IF, 1); cyc_s("beq_z1", T_ID, 1); cyc_s("beq_z1", T_EXB, 1);
    set_ir(6'h04, 6'h00, 1'b0);
    cyc_s("beq_z0", T_IF, 1); cyc_s("beq_z0", T_ID, 1); cyc_s("beq_z0", T_EXB, 1);
    set_ir(6'h02, 6'h00, 1'b0);
    cyc_s("j", T_IF, 1); cyc_s("j", T_ID, 1); cyc_s("j", T_EXJ, 1);
    set_ir(6'h03, 6'h00, 1'b0);
    cyc_s("jal", T_IF, 1); cyc_s("jal", T_ID, 1); cyc_s("jal", T_JAL, 1);

    // Ready on the last permitted wait cycle wins; counter restarts per state.
    set_ir(6'h23, 6'h00, 1'b0);
    for (int i = 0; i < 3; i++) cyc_s("lw_edge", T_IF, 0);
    cyc_s("lw_edge", T_IF, 1); cyc_s("lw_edge", T_ID, 1); cyc_s("lw_edge", T_EXM, 1);
    for (int i = 0; i < 3; i++) cyc_s("lw_edge", T_MRD, 0);
    cyc_s("lw_edge", T_MRD, 1); cyc_s("lw_edge", T_WBM, 1);

    set_ir(6'h00, 6'h08, 1'b0);
    cyc_s("jr", T_IF, 1); cyc_s("jr", T_ID, 1);
    cyc("jr", T_TRAP, T_JR, 1, 2'b10, 2'b00);
    cyc("jr_hold", T_TRAP, T_IF, 0, 2'b10, 2'b00);
    reset_pulse("rst_after_jr");

    set_ir(6'h00, 6'h20, 1'b0);
    cyc_s("badfn", T_IF, 1); cyc_s("badfn", T_ID, 1);
    cyc("badfn", T_TRAP, T_TRAP, 1, 2'b10, 2'b10);
    reset_pulse("rst_after_badfn");

    set_ir(6'h00, 6'h21, 1'b0);
    for (int i = 0; i < 4; i++) cyc_s("tmo", T_IF, 0);
    cyc("tmo", T_TRAP, T_IF, 0, 2'b01, 2'b00);
    cyc("tmo_hold", T_TRAP, T_IF, 1, 2'b01, 2'b00);
    reset_pulse("rst_after_tmo");

    set_ir(6'h2B, 6'h00, 1'b0);
    cyc_s("sw_rst", T_IF, 1); cyc_s("sw_rst", T_ID, 1); cyc_s("sw_rst", T_EXM, 1);
    cyc_s("sw_rst", T_MWR, 0);
    #1;
    check("sw_rst/pre_mem_wr", 32'(bus0.mem_wr), 32'd1);
    reset_pulse("rst_mid_mwr");
    set_ir(6'h02, 6'h00, 1'b0);
    cyc_s("j_after", T_IF, 1); cyc_s("j_after", T_ID, 1); cyc_s("j_after", T_EXJ, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states, driving datapath enables per cycle.
- Stalls on a memory ready handshake and flags illegal opcodes and memory timeouts.
- Sits between the instruction register (op/func) and the shared multi-cycle datapath (PC, IR, regfile, ALU, unified memory).

Parameters:
- ALUCTR_W, 3: width of alu_ctr. Codes are ADD=0, SUB=1, LUI=3, OR=4; zero-extended above 3 bits.
- HAS_JR, 1: 1 decodes jr (op=000000, func=001000); 0 makes jr illegal.
- WAIT_TIMEOUT, 0: maximum wait cycles on mem_ready before mem_timeout; 0 disables the check.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_wr  out  1  unconditional PC write
- pc_wr_cond  out  1  PC write if zero
- npc_sel  out  2  00 ALU result, 01 branch target reg, 10 jump target, 11 rs (jr)
- ir_wr  out  1  latch instruction
- i_or_d  out  1  memory address: 0 PC, 1 ALU out
- mem_req  out  1  memory access request
- mem_wr  out  1  write (valid with mem_req)
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALU out, 01 MDR, 10 PC
- reg_wr  out  1  regfile write
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
- ext_op  out  1  1 sign, 0 zero extend
- alu_ctr  out  ALUCTR_W  ALU operation
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  sticky error
- mem_timeout  out  1  sticky error
- state_dbg  out  4  current state encoding

Behaviour:
- Reset (async, rst_n low):
  - State goes to IF.
  - The timeout counter clears to 0.
  - illegal_op and mem_timeout clear to 0.
  - All other outputs are Moore decodes of the state, so they are 0 while in reset except IF defaults.
- Reset mid-instruction: the instruction is abandoned and there are no partial writes. Decode is combinational on state, so reg_wr, mem_wr and pc_wr drop immediately when rst_n falls.
- States (4-bit encoding): IF=0, ID=1, EX_R=2, EX_I=3, EX_MEMADR=4, EX_BR=5, EX_J=6, EX_JAL=7, EX_JR=8, MEM_RD=9, MEM_WR=10, WB_R=11, WB_I=12, WB_MEM=13, TRAP=15.
- IF:
  - Outputs: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctr=ADD.
  - ir_wr=1 and pc_wr=1 (npc_sel=00) only in the cycle mem_ready=1; then go to ID. Otherwise stay in IF.
- ID:
  - Outputs: alu_src_a=0, alu_src_b=11, ext_op=1, alu_ctr=ADD (branch target precompute).
  - Dispatch on op:
    - 000000: addu (func 100001) or subu (func 100011) go to EX_R; jr goes to EX_JR when HAS_JR=1.
    - ori (001101) and lui (001111) go to EX_I.
    - lw (100011) and sw (101011) go to EX_MEMADR.
    - beq (000100) goes to EX_BR; j (000010) goes to EX_J; jal (000011) goes to EX_JAL.
    - Anything else goes to TRAP.
- EX_R: alu_src_a=1, alu_src_b=00, alu_ctr=SUB if func=100011 else ADD. Next state WB_R.
- EX_I: alu_src_a=1, alu_src_b=10, ext_op=0, alu_ctr=OR for ori or LUI for lui. Next state WB_I.
- EX_MEMADR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_ctr=ADD. Next state MEM_RD for lw, MEM_WR for sw.
- EX_BR: alu_src_a=1, alu_src_b=00, alu_ctr=SUB, pc_wr_cond=1, npc_sel=01, instr_done=1. Next state IF.
- EX_J: pc_wr=1, npc_sel=10, instr_done=1. Next state IF.
- EX_JAL: pc_wr=1, npc_sel=10, reg_wr=1, reg_dst=10, mem_to_reg=10 (PC already +4), instr_done=1. Next state IF.
- EX_JR: pc_wr=1, npc_sel=11, instr_done=1. Next state IF.
- MEM_RD: mem_req=1, i_or_d=1. Waits on mem_ready, then goes to WB_MEM.
- MEM_WR: mem_req=1, mem_wr=1, i_or_d=1. Waits on mem_ready; on completion pulses instr_done and goes to IF.
- WB_R: reg_wr=1, reg_dst=01, mem_to_reg=00, instr_done=1. Next state IF.
- WB_I: reg_wr=1, reg_dst=00, mem_to_reg=00, instr_done=1. Next state IF.
- WB_MEM: reg_wr=1, reg_dst=00, mem_to_reg=01, instr_done=1. Next state IF.
- Latency with mem_ready tied high:
  - beq, j, jal, jr: 3 cycles.
  - addu, subu, ori, lui, sw: 4 cycles.
  - lw: 5 cycles.
  - Each extra wait cycle adds 1.
- Timeout (WAIT_TIMEOUT>0):
  - The counter increments each cycle in IF, MEM_RD or MEM_WR while mem_ready=0, and clears on mem_ready=1 or on state change.
  - When the counter reaches WAIT_TIMEOUT: set mem_timeout and go to TRAP. mem_ready arriving in that same cycle wins, i.e. no timeout.
- TRAP:
  - All enables are 0; the block stays in TRAP until reset.
  - illegal_op is set on ID→TRAP; mem_timeout is set on timeout→TRAP.
- Hazard rule: pc_wr and pc_wr_cond are never asserted in the same cycle. mem_wr is never asserted without mem_req.

Decomposition:
- Shared package mc_pkg holds:
  - opcode/func constants;
  - the state enum (4-bit);
  - alu_ctr codes ADD, SUB, LUI, OR;
  - mux select encodings for npc_sel, reg_dst, mem_to_reg and alu_src_b.
- One natural sub-module: mc_wait_timer (counter plus compare, parametrised by WAIT_TIMEOUT).

Test Plan:
- addu (op=0, func=100001), mem_ready=1 → states IF,ID,EX_R,WB_R; reg_wr=1 with reg_dst=01 in cycle 4; instr_done on cycle 4 only.
- lw (op=100011), mem_ready low 2 cycles in MEM_RD → 7 cycles total; reg_wr=1 with mem_to_reg=01 in the last cycle; mem_req held all 3 MEM_RD cycles.
- beq with zero=1 then zero=0 → pc_wr_cond=1 with npc_sel=01 in cycle 3 both times; instr_done in cycle 3.
- jal → cycle 3 shows pc_wr=1, npc_sel=10, reg_wr=1, reg_dst=10, mem_to_reg=10; then jr with HAS_JR=0 → illegal_op=1, state_dbg=15.
- WAIT_TIMEOUT=4 with mem_ready stuck 0 in IF → mem_timeout=1 after the 4th wait cycle; state_dbg=15 and no further ir_wr.
- rst_n dropped during the MEM_WR wait → mem_wr=0 immediately; state_dbg=0 after release; the sticky flags are cleared.
